// File: rtl/eeprom_slave.sv
// I2C-style serial EEPROM responder: decodes START/STOP, control/address/data bytes,
// ACKs over open-drain SDA and serves a 2048x8 byte array with an 11-bit wrapping pointer.
`timescale 1ns/1ps

module eeprom_slave #(
  parameter logic [3:0]  DEV_TYPE  = 4'b1010,
  parameter int unsigned MEM_DEPTH = 2048
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SCL,
  inout  wire         SDA,
  output logic        BUSY,
  output logic        WR_DONE,
  output logic [10:0] ADDR_PTR
);

  localparam int unsigned AW = 11;
  localparam int unsigned BW = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CTRL,
    S_CTRL_ACK,
    S_ADDR,
    S_ADDR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_MACK,
    S_IGNORE
  } state_t;

  state_t          state;
  logic [BW-1:0]   bit_cnt;
  logic [7:0]      shreg;
  logic [7:0]      txreg;
  logic            rw;
  logic            mack;
  logic            sda_oe;

  logic [1:0]      scl_sync;
  logic [1:0]      sda_sync;
  logic            scl_d;
  logic            sda_d;

  logic [7:0]      mem [MEM_DEPTH];

  logic            scl_rise_c;
  logic            scl_fall_c;
  logic            start_c;
  logic            stop_c;
  logic            byte_done_c;
  logic            shift_c;
  logic            mem_we_c;
  logic [7:0]      rd_byte_c;

  // Open-drain: only ever pull low or release.
  assign SDA = sda_oe ? 1'b0 : 1'bz;

  // Two-flop synchronizers plus one delayed copy for edge detection.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], SCL};
      sda_sync <= {sda_sync[0], SDA};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl_rise_c  = scl_sync[1] & ~scl_d;
  assign scl_fall_c  = ~scl_sync[1] & scl_d;
  assign start_c     = scl_sync[1] & scl_d & sda_d & ~sda_sync[1];
  assign stop_c      = scl_sync[1] & scl_d & ~sda_d & sda_sync[1];
  assign byte_done_c = (bit_cnt == BW'(8));
  assign shift_c     = scl_rise_c && !byte_done_c &&
                       (state inside {S_CTRL, S_ADDR, S_WDATA, S_RDATA});
  assign mem_we_c    = (state == S_WDATA) && scl_fall_c && byte_done_c;
  assign rd_byte_c   = mem[ADDR_PTR];

  // Byte array has no reset so contents survive RESET.
  always_ff @(posedge CLK) begin
    if (mem_we_c) begin
      mem[ADDR_PTR] <= shreg;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      txreg    <= '0;
      rw       <= 1'b0;
      mack     <= 1'b0;
      sda_oe   <= 1'b0;
      BUSY     <= 1'b0;
      WR_DONE  <= 1'b0;
      ADDR_PTR <= '0;
    end else begin
      WR_DONE <= 1'b0;
      if (start_c) begin
        state   <= S_CTRL;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        BUSY    <= 1'b1;
      end else if (stop_c) begin
        state   <= S_IDLE;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        BUSY    <= 1'b0;
      end else begin
        if (shift_c) begin
          shreg   <= {shreg[6:0], sda_sync[1]};
          bit_cnt <= bit_cnt + BW'(1);
        end
        case (state)
          S_CTRL: begin
            if (scl_fall_c && byte_done_c) begin
              bit_cnt <= '0;
              if (shreg[7:4] == DEV_TYPE) begin
                state  <= S_CTRL_ACK;
                sda_oe <= 1'b1;
                rw     <= shreg[0];
                if (!shreg[0]) begin
                  ADDR_PTR[10:8] <= shreg[3:1];
                end
              end else begin
                state <= S_IGNORE;
              end
            end
          end
          S_CTRL_ACK: begin
            if (scl_fall_c) begin
              if (rw) begin
                state  <= S_RDATA;
                txreg  <= rd_byte_c;
                sda_oe <= ~rd_byte_c[7];
              end else begin
                state  <= S_ADDR;
                sda_oe <= 1'b0;
              end
            end
          end
          S_ADDR: begin
            if (scl_fall_c && byte_done_c) begin
              bit_cnt       <= '0;
              ADDR_PTR[7:0] <= shreg;
              state         <= S_ADDR_ACK;
              sda_oe        <= 1'b1;
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall_c) begin
              state  <= S_WDATA;
              sda_oe <= 1'b0;
            end
          end
          // Commit happens on the fall that opens the ACK clock; partial bytes never reach here.
          S_WDATA: begin
            if (mem_we_c) begin
              bit_cnt  <= '0;
              WR_DONE  <= 1'b1;
              ADDR_PTR <= ADDR_PTR + AW'(1);
              state    <= S_WDATA_ACK;
              sda_oe   <= 1'b1;
            end
          end
          S_WDATA_ACK: begin
            if (scl_fall_c) begin
              state  <= S_WDATA;
              sda_oe <= 1'b0;
            end
          end
          S_RDATA: begin
            if (scl_fall_c) begin
              if (byte_done_c) begin
                bit_cnt <= '0;
                state   <= S_MACK;
                sda_oe  <= 1'b0;
              end else begin
                txreg  <= {txreg[6:0], 1'b0};
                sda_oe <= ~txreg[6];
              end
            end
          end
          S_MACK: begin
            if (scl_rise_c) begin
              mack     <= ~sda_sync[1];
              ADDR_PTR <= ADDR_PTR + AW'(1);
            end else if (scl_fall_c) begin
              if (mack) begin
                state  <= S_RDATA;
                txreg  <= rd_byte_c;
                sda_oe <= ~rd_byte_c[7];
              end else begin
                state <= S_IGNORE;
              end
            end
          end
          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eeprom_slave.sv
// Directed and randomized bus transactions against an array/pointer reference model
// of the EEPROM, acting as the I2C master with open-drain SDA.
`timescale 1ns/1ps

module tb_eeprom_slave;

  logic        clk;
  logic        rst_n;
  logic        scl;
  logic        sda_m_oe;
  wire         sda_w;
  logic        busy;
  logic        wr_done;
  logic [10:0] addr_ptr;

  pullup (sda_w);
  assign sda_w = sda_m_oe ? 1'b0 : 1'bz;

  eeprom_slave dut (
    .CLK      (clk),
    .RESET    (rst_n),
    .SCL      (scl),
    .SDA      (sda_w),
    .BUSY     (busy),
    .WR_DONE  (wr_done),
    .ADDR_PTR (addr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] model [2048];
  int         mptr;
  logic [7:0] wdata [4];

  int   wr_pulses = 0;
  int   wr_long   = 0;
  int   slave_low = 0;
  logic wr_prev   = 1'b0;

  always @(negedge clk) begin
    if (wr_done === 1'b1) wr_pulses++;
    if (wr_done === 1'b1 && wr_prev === 1'b1) wr_long++;
    wr_prev = wr_done;
    if (!sda_m_oe && sda_w === 1'b0) slave_low++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL clock: set SDA while low, pulse SCL high, sample line near end of high.
  task automatic bus_bit(input logic b, output logic seen);
    tick(4);
    sda_m_oe = ~b;
    tick(4);
    scl = 1'b1;
    tick(6);
    seen = sda_w;
    scl = 1'b0;
  endtask

  task automatic start_cond();
    tick(4);
    sda_m_oe = 1'b0;
    tick(4);
    scl = 1'b1;
    tick(6);
    sda_m_oe = 1'b1;
    tick(6);
    scl = 1'b0;
  endtask

  task automatic stop_cond();
    tick(4);
    sda_m_oe = 1'b1;
    tick(4);
    scl = 1'b1;
    tick(6);
    sda_m_oe = 1'b0;
    tick(6);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    ack = (s === 1'b0);
  endtask

  task automatic read_byte(input logic give_ack, output logic [7:0] d, output logic ninth);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      d[i] = s;
    end
    bus_bit(~give_ack, ninth);
  endtask

  task automatic write_txn(input logic [7:0] ctrl, input logic [7:0] addr, input int n);
    logic ack;
    int   wr0;
    wr0 = wr_pulses;
    start_cond();
    chk("busy_after_start", busy, 1);
    send_byte(ctrl, ack);
    chk("wr_ctrl_ack", ack, 1);
    send_byte(addr, ack);
    chk("wr_addr_ack", ack, 1);
    mptr = int'(ctrl[3:1]) * 256 + int'(addr);
    for (int k = 0; k < n; k++) begin
      send_byte(wdata[k], ack);
      chk("wr_data_ack", ack, 1);
      model[mptr] = wdata[k];
      mptr = (mptr + 1) % 2048;
    end
    stop_cond();
    chk("busy_after_stop", busy, 0);
    chk("wr_ptr", 32'(addr_ptr), 32'(mptr));
    chk("wr_done_count", 32'(wr_pulses - wr0), 32'(n));
    chk("wr_done_width", 32'(wr_long), 0);
  endtask

  task automatic read_txn(input logic [10:0] a, input int n);
    logic       ack;
    logic       ninth;
    logic [7:0] d;
    int         wr0;
    wr0 = wr_pulses;
    start_cond();
    send_byte({4'hA, a[10:8], 1'b0}, ack);
    chk("rd_ctrlw_ack", ack, 1);
    send_byte(a[7:0], ack);
    chk("rd_addr_ack", ack, 1);
    start_cond();
    send_byte({4'hA, 3'($urandom), 1'b1}, ack);
    chk("rd_ctrlr_ack", ack, 1);
    mptr = int'(a);
    for (int k = 0; k < n; k++) begin
      read_byte(k != n - 1, d, ninth);
      chk("rd_data", 32'(d), 32'(model[mptr]));
      if (k == n - 1) chk("rd_release_9th", ninth, 1);
      mptr = (mptr + 1) % 2048;
    end
    stop_cond();
    chk("rd_ptr", 32'(addr_ptr), 32'(mptr));
    chk("rd_no_wr_done", 32'(wr_pulses - wr0), 0);
    chk("rd_busy_low", busy, 0);
  endtask

  initial begin
    logic ack;
    logic s;
    int   low0;
    int   wr0;
    int   a;
    int   n;

    rst_n    = 1'b0;
    scl      = 1'b1;
    sda_m_oe = 1'b0;
    mptr     = 0;
    tick(3);
    chk("reset_busy", busy, 0);
    chk("reset_wr_done", wr_done, 0);
    chk("reset_ptr", 32'(addr_ptr), 0);
    chk("reset_sda", sda_w, 1);
    rst_n = 1'b1;
    tick(5);

    // Byte write then random read of the same location.
    wdata[0] = 8'h5A;
    write_txn(8'hA2, 8'h23, 1);
    chk("byte_write_ptr", 32'(addr_ptr), 32'h124);
    read_txn(11'h123, 1);

    // Wrong device type: never acknowledged, nothing written.
    wdata[0] = 8'h5C;
    write_txn(8'hA2, 8'h00, 1);
    low0 = slave_low;
    wr0  = wr_pulses;
    a    = int'(addr_ptr);
    start_cond();
    send_byte(8'hB2, ack);
    chk("wrongdev_ctrl_nack", ack, 0);
    send_byte(8'h00, ack);
    chk("wrongdev_addr_nack", ack, 0);
    send_byte(8'hFF, ack);
    chk("wrongdev_data_nack", ack, 0);
    stop_cond();
    chk("wrongdev_sda_never_low", 32'(slave_low - low0), 0);
    chk("wrongdev_no_wr_done", 32'(wr_pulses - wr0), 0);
    chk("wrongdev_ptr_kept", 32'(addr_ptr), 32'(a));
    read_txn(11'h100, 1);

    // Sequential write and read across the 0x7FF -> 0x000 wrap.
    wdata[0] = 8'h11;
    wdata[1] = 8'h22;
    write_txn(8'hAE, 8'hFF, 2);
    read_txn(11'h7FF, 2);
    chk("wrap_ptr", 32'(addr_ptr), 32'h001);

    // START after 4 data bits aborts the byte; next control byte still ACKed.
    wdata[0] = 8'h77;
    write_txn(8'hA0, 8'h10, 1);
    wr0 = wr_pulses;
    start_cond();
    send_byte(8'hA0, ack);
    chk("abort_ctrl_ack", ack, 1);
    send_byte(8'h10, ack);
    chk("abort_addr_ack", ack, 1);
    for (int i = 0; i < 4; i++) bus_bit(1'b1, s);
    start_cond();
    send_byte(8'hA0, ack);
    chk("abort_next_ctrl_ack", ack, 1);
    stop_cond();
    chk("abort_no_wr_done", 32'(wr_pulses - wr0), 0);
    chk("abort_ptr", 32'(addr_ptr), 32'h010);
    read_txn(11'h010, 1);

    // Reset while the slave is pulling SDA low for a 0 data bit.
    wdata[0] = 8'h3C;
    write_txn(8'hA0, 8'h55, 1);
    start_cond();
    send_byte(8'hA0, ack);
    send_byte(8'h55, ack);
    start_cond();
    send_byte(8'hA1, ack);
    chk("rst_rd_ctrl_ack", ack, 1);
    tick(6);
    chk("rst_rd_bit7_low", sda_w, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_sda_released", sda_w, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ptr", 32'(addr_ptr), 0);
    tick(3);
    rst_n = 1'b1;
    mptr  = 0;
    stop_cond();
    wdata[0] = 8'hC3;
    write_txn(8'hA0, 8'hAB, 1);
    read_txn(11'h0AB, 1);
    read_txn(11'h055, 1);

    // Randomized writes, each read back through the model.
    for (int it = 0; it < 6; it++) begin
      logic [10:0] ra;
      ra = 11'($urandom_range(0, 2047));
      n  = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++) wdata[k] = 8'($urandom);
      write_txn({4'hA, ra[10:8], 1'b0}, ra[7:0], n);
      read_txn(ra, n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
